rf_dump_seq: RTL and testbench
==============================

# rf_dump_seq

Register-file snapshot sequencer for the NPC trace/difftest path. On each commit it freezes the core and walks a dedicated synchronous read port of the integer register file, index 0 to NREGS-1. It streams one `{idx, data}` beat per register over a valid/ready interface to the trace consumer, then releases the core. This replaces the one-shot whole-array DPI export with a bounded-bandwidth, backpressure-aware stream.

## Interface
Parameters:
- `XLEN`, default 64: register and PC width.
- `NREGS`, default 32: registers per snapshot; must be a power of two; `IW = $clog2(NREGS)`.

Ports:
- `clock`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when low, commits in IDLE are ignored.
- `commit_valid`, in, 1: one-cycle pulse; the retiring instruction's regfile write lands at the end of this cycle.
- `commit_pc`, in, XLEN: PC of the retiring instruction; sampled with `commit_valid`.
- `core_stall`, out, 1: freezes retirement and regfile writes.
- `rf_raddr`, out, IW: read-port address.
- `rf_ren`, out, 1: read enable.
- `rf_rdata`, in, XLEN: read data, valid one cycle after `rf_ren`.
- `trace_valid`, out, 1: beat valid.
- `trace_ready`, in, 1: consumer ready.
- `trace_idx`, out, IW: register index of the beat.
- `trace_data`, out, XLEN: register value of the beat.
- `trace_pc`, out, XLEN: latched `commit_pc`; constant for the whole snapshot.
- `trace_last`, out, 1: high on the beat with `idx == NREGS-1`.
- `dump_done`, out, 1: one-cycle pulse after the last beat is accepted.
- `overrun`, out, 1: sticky; set when a commit arrives while not IDLE.

## Operation
- States:
  - IDLE → DUMP on `commit_valid && enable`.
  - DUMP → DRAIN after the read for `idx NREGS-1` is issued.
  - DRAIN → DONE when nothing is in flight, the FIFO is empty and no beat is pending.
  - DONE → IDLE unconditionally.
- DONE is a single cycle and drives `dump_done = 1`.
- `core_stall = 1` in DUMP, DRAIN and DONE; 0 in IDLE.
- Read issue, DUMP only:
  - `rf_ren = 1` when `fifo_count + inflight - pop < 2`, where `pop = trace_valid & trace_ready`.
  - `rf_raddr` is the issue counter, starting at 0 and incrementing on each issue.
  - Reads are never re-issued.
- Output buffer is a 2-entry FIFO holding `{idx, data}`:
  - The entry is written on the cycle after issue, with `rf_rdata` and the delayed index.
  - The head drives the `trace_*` outputs.
  - The credit rule guarantees the FIFO never overflows.
- `trace_last` = head valid && head idx == NREGS-1.
- `x0` is read through the port like any other register; no special-casing.
- A commit while not IDLE sets `overrun`. That commit is dropped and the running dump is unaffected. `overrun` is cleared only by reset.
- `enable` deasserting mid-dump has no effect; the dump completes.
- Handshake rules:
  - Once `trace_valid` rises, the beat's `idx`, `data`, `pc` and `last` stay stable until accepted.
  - `trace_valid` does not depend combinationally on `trace_ready`.

## Timing
- Reset values: `core_stall`, `rf_ren`, `trace_valid`, `trace_last`, `dump_done` and `overrun` are 0. `rf_raddr`, `trace_idx`, `trace_data` and `trace_pc` are 0. State is IDLE, FIFO empty, counters 0.
- Reset may assert mid-dump: it aborts immediately, with no beat or `done` emitted.
- Commit in cycle 0:
  - Cycle 1: DUMP, `core_stall = 1`, `rf_ren = 1` with `raddr = 0`.
  - Cycle 2: `rdata` for idx 0 is valid and is written into the FIFO.
  - Cycle 3: first beat, `trace_valid = 1`.
- With `trace_ready` held at 1: one beat per cycle, beats in cycles 3..34 for NREGS=32, last beat in cycle 34, `dump_done` in cycle 35, `core_stall` low from cycle 36.
- A new commit is accepted from cycle 36.
- Backpressure stalls reads within one cycle. At most 2 reads are outstanding or buffered, so no data is lost.
- Minimum snapshot latency, commit to `dump_done`: NREGS + 3 cycles.

## Structure
- Shared package `npc_trace_pkg`:
  - `XLEN`, `NREGS`, `IW`.
  - State enum `rf_dump_state_e` (IDLE, DUMP, DRAIN, DONE).
  - Struct `rf_beat_t` {idx, data}.
- Sub-module `rf_dump_fifo2`: 2-entry `rf_beat_t` FIFO with count output.
- The top level holds the FSM, issue counter, in-flight flag, PC latch and overrun flag.

## Test plan
- Regfile preloaded with x_i = 0x1000+i; commit (pc 0x80000000) with ready=1 → 32 beats in cycles 3..34, idx 0..31, data 0x1000..0x101F, pc constant, last only on idx 31, `dump_done` in cycle 35, stall cycles 1..35.
- Ready toggling 1-0-1-0 → all 32 beats in order with no duplicates, fields stable while stalled, `rf_ren` never has more than 2 outstanding or buffered.
- Ready low for 20 cycles mid-dump (after idx 5) → reads stop with at most 2 buffered, then resume at the correct index; `dump_done` is delayed by 20 cycles.
- Commit pulse in cycle 10 during a dump → `overrun = 1` permanently; the dump output is unchanged; no second dump follows.
- `enable = 0` with a commit → no stall, no beats; `enable` dropped mid-dump → the dump completes normally.
- `reset_n` asserted in cycle 15 of a dump → all outputs 0 immediately; a subsequent commit gives a full, clean 32-beat dump.

Source files
------------

// File: rtl/npc_trace_pkg.sv
// ----------------------------------------------------------------------------
// npc_trace_pkg: shared types for the NPC trace/difftest path (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package npc_trace_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int IW    = $clog2(NREGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMP  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rf_dump_state_e;

  typedef struct packed {
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] data;
  } rf_beat_t;

endpackage

`default_nettype wire

// File: rtl/rf_dump_fifo2.sv
// ----------------------------------------------------------------------------
// rf_dump_fifo2: two-entry beat buffer with occupancy count (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module rf_dump_fifo2
  import npc_trace_pkg::*;
#(
  parameter type T = rf_beat_t
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output T           head,
  output logic [1:0] count
);

  T     mem [2];
  logic wr_ptr;
  logic rd_ptr;

  // The caller's credit scheme guarantees no push when full and no pop when empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/rf_dump_seq.sv
// ----------------------------------------------------------------------------
// rf_dump_seq: per-commit register-file snapshot streamer (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module rf_dump_seq #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  output logic            core_stall,
  output logic [IW-1:0]   rf_raddr,
  output logic            rf_ren,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [IW-1:0]   trace_idx,
  output logic [XLEN-1:0] trace_data,
  output logic [XLEN-1:0] trace_pc,
  output logic            trace_last,
  output logic            dump_done,
  output logic            overrun
);

  import npc_trace_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

  typedef struct packed {
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] data;
  } beat_t;

  rf_dump_state_e  state;
  logic [IW-1:0]   issue_idx;
  logic [IW-1:0]   inflight_idx;
  logic            inflight;
  logic [XLEN-1:0] pc_q;
  logic            stall_q;
  logic            done_q;
  logic            overrun_q;

  beat_t           head;
  beat_t           push_beat;
  logic [1:0]      fifo_count;
  logic            pop;
  logic            issue;
  logic            drain_empty;
  logic [2:0]      credit_used;

  assign pop = trace_valid & trace_ready;

  // Entries that will still occupy the buffer after this cycle's pop; keeping
  // it below two before issuing means the 2-entry FIFO can never overflow.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == DUMP) && (credit_used < 3'd2);

  // Empty next cycle: nothing returning from the port and the last entry leaving now.
  assign drain_empty = !inflight && (fifo_count == {1'b0, pop});

  assign push_beat.idx  = inflight_idx;
  assign push_beat.data = rf_rdata;

  rf_dump_fifo2 #(
    .T (beat_t)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      issue_idx    <= '0;
      inflight_idx <= '0;
      inflight     <= 1'b0;
      pc_q         <= '0;
      stall_q      <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (commit_valid && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end

      inflight <= issue;
      if (issue) begin
        inflight_idx <= issue_idx;
        issue_idx    <= issue_idx + IW'(1);
      end

      case (state)
        IDLE: begin
          if (commit_valid && enable) begin
            state     <= DUMP;
            pc_q      <= commit_pc;
            issue_idx <= '0;
            stall_q   <= 1'b1;
          end
        end
        DUMP: begin
          if (issue && (issue_idx == LAST_IDX)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          stall_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign core_stall  = stall_q;
  assign dump_done   = done_q;
  assign rf_ren      = issue;
  assign rf_raddr    = issue_idx;
  assign trace_valid = (fifo_count != 2'd0);
  assign trace_idx   = head.idx;
  assign trace_data  = head.data;
  assign trace_pc    = pc_q;
  assign trace_last  = trace_valid && (head.idx == LAST_IDX);
  assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_dump_seq.sv
// ----------------------------------------------------------------------------
// tb_rf_dump_seq: randomized self-checking bench for rf_dump_seq (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rf_dump_seq;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int IW    = 5;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            commit_valid = 1'b0;
  logic [XLEN-1:0] commit_pc = '0;
  logic            trace_ready = 1'b0;
  logic [XLEN-1:0] rf_rdata;
  logic            core_stall, rf_ren, trace_valid, trace_last, dump_done, overrun;
  logic [IW-1:0]   rf_raddr, trace_idx;
  logic [XLEN-1:0] trace_data, trace_pc;

  logic [XLEN-1:0] rf [NREGS];
  int checks = 0;
  int failures = 0;

  // Observations gathered by run_dump, judged by the individual tests.
  int              b_idx[$];
  logic [XLEN-1:0] b_data[$];
  logic [XLEN-1:0] b_pc[$];
  bit              b_last[$];
  int              b_cyc[$];
  int              iss[$];
  int done_cyc, done_cnt, stall_cnt, stall_first_low, max_out, stab_err;
  int ovr_first, hold_out;
  bit got_overrun;

  rf_dump_seq #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .core_stall   (core_stall),
    .rf_raddr     (rf_raddr),
    .rf_ren       (rf_ren),
    .rf_rdata     (rf_rdata),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_idx    (trace_idx),
    .trace_data   (trace_data),
    .trace_pc     (trace_pc),
    .trace_last   (trace_last),
    .dump_done    (dump_done),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  // Synchronous-read register file port.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) rf_rdata <= '0;
    else if (rf_ren) rf_rdata <= rf[rf_raddr];
  end

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // mode: 0 ready high, 1 ready on odd cycles, 2 random ready, 3 ready low for 20 cycles after idx 5.
  task automatic run_dump(input int mode, input logic [XLEN-1:0] pc, input int extra_commit,
                          input int drop_en, input int max_cyc);
    int outstanding = 0;
    int hold_start = -1;
    bit pv = 0;
    logic [IW-1:0] pidx = '0;
    logic [XLEN-1:0] pdata = '0, ppc = '0;
    logic plast = 1'b0;
    b_idx.delete(); b_data.delete(); b_pc.delete(); b_last.delete(); b_cyc.delete(); iss.delete();
    done_cyc = -1; done_cnt = 0; stall_cnt = 0; stall_first_low = -1; max_out = 0;
    stab_err = 0; ovr_first = -1; hold_out = -1;
    @(negedge clock);
    commit_valid = 1'b1;
    commit_pc    = pc;
    trace_ready  = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock);
      commit_valid = (c == extra_commit);
      commit_pc    = rnd64();
      if (c == drop_en) enable = 1'b0;
      case (mode)
        1:       trace_ready = c[0];
        2:       trace_ready = 1'($urandom_range(0, 1));
        3:       trace_ready = !(hold_start >= 0 && c >= hold_start && c < hold_start + 20);
        default: trace_ready = 1'b1;
      endcase
      #1;
      if (core_stall) stall_cnt++;
      else if (stall_first_low < 0) stall_first_low = c;
      if (overrun && ovr_first < 0) ovr_first = c;
      if (rf_ren) begin iss.push_back(int'(rf_raddr)); outstanding++; end
      if (trace_valid && trace_ready) outstanding--;
      if (outstanding > max_out) max_out = outstanding;
      if (pv && (!trace_valid || trace_idx !== pidx || trace_data !== pdata ||
                 trace_pc !== ppc || trace_last !== plast)) stab_err++;
      if (trace_valid && trace_ready) begin
        b_idx.push_back(int'(trace_idx)); b_data.push_back(trace_data);
        b_pc.push_back(trace_pc); b_last.push_back(trace_last); b_cyc.push_back(c);
        if (mode == 3 && hold_start < 0 && trace_idx == 5) hold_start = c + 1;
      end
      if (mode == 3 && hold_start >= 0 && c == hold_start + 19) hold_out = outstanding;
      pv = trace_valid && !trace_ready;
      pidx = trace_idx; pdata = trace_data; ppc = trace_pc; plast = trace_last;
      if (dump_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c >= done_cyc + 10) break;
    end
    got_overrun  = overrun;
    commit_valid = 1'b0;
    trace_ready  = 1'b0;
    enable       = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    commit_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({core_stall, rf_ren, trace_valid, trace_last, dump_done, overrun} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {core_stall, rf_ren, trace_valid, trace_last, dump_done, overrun});
    end
    checks++;
    if (rf_raddr !== '0 || trace_idx !== '0 || trace_data !== '0 || trace_pc !== '0) begin
      failures++;
      $display("FAIL reset_fields got raddr=%0d idx=%0d data=%h pc=%h exp=all zero",
               rf_raddr, trace_idx, trace_data, trace_pc);
    end
    commit_valid = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (core_stall !== 1'b0 || trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got stall=%b valid=%b exp=0 0", core_stall, trace_valid);
    end
  endtask

  task automatic test_full_dump();
    logic [XLEN-1:0] pc = 64'h8000_0000;
    bit bad = 0;
    for (int i = 0; i < NREGS; i++) rf[i] = 64'h1000 + 64'(i);
    run_dump(0, pc, -1, -1, 200);
    checks++;
    if (b_idx.size() != NREGS) begin
      failures++; $display("FAIL full_beat_count got=%0d exp=%0d", b_idx.size(), NREGS);
    end
    for (int i = 0; i < b_idx.size(); i++) begin
      checks++;
      if (b_idx[i] != i || b_data[i] !== 64'h1000 + 64'(i) || b_pc[i] !== pc ||
          b_last[i] !== (i == NREGS - 1) || b_cyc[i] != 3 + i) begin
        failures++;
        $display("FAIL full_beat[%0d] got idx=%0d data=%h pc=%h last=%b cyc=%0d exp idx=%0d data=%h pc=%h last=%b cyc=%0d",
                 i, b_idx[i], b_data[i], b_pc[i], b_last[i], b_cyc[i],
                 i, 64'h1000 + 64'(i), pc, (i == NREGS - 1), 3 + i);
      end
    end
    checks++;
    if (done_cyc != NREGS + 3 || done_cnt != 1) begin
      failures++; $display("FAIL full_done got cyc=%0d cnt=%0d exp cyc=%0d cnt=1", done_cyc, done_cnt, NREGS + 3);
    end
    checks++;
    if (stall_cnt != NREGS + 3 || stall_first_low != NREGS + 4) begin
      failures++;
      $display("FAIL full_stall got cycles=%0d first_low=%0d exp cycles=%0d first_low=%0d",
               stall_cnt, stall_first_low, NREGS + 3, NREGS + 4);
    end
    foreach (iss[i]) if (iss[i] != i) bad = 1;
    checks++;
    if (bad || iss.size() != NREGS) begin
      failures++; $display("FAIL full_issue_order got count=%0d in_order=%b exp count=%0d in_order=1", iss.size(), !bad, NREGS);
    end
  endtask

  task automatic test_ready_toggle();
    logic [XLEN-1:0] pc = rnd64();
    bit bad = 0;
    for (int i = 0; i < NREGS; i++) rf[i] = rnd64();
    run_dump(1, pc, -1, -1, 300);
    checks++;
    if (b_idx.size() != NREGS) begin
      failures++; $display("FAIL toggle_beat_count got=%0d exp=%0d", b_idx.size(), NREGS);
    end
    for (int i = 0; i < b_idx.size(); i++)
      if (b_idx[i] != i || b_data[i] !== rf[i] || b_pc[i] !== pc) bad = 1;
    checks++;
    if (bad) begin failures++; $display("FAIL toggle_beats got=out_of_order_or_wrong exp=idx 0..31 with rf data"); end
    checks++;
    if (stab_err != 0 || max_out > 2) begin
      failures++; $display("FAIL toggle_handshake got stab_err=%0d max_out=%0d exp stab_err=0 max_out<=2", stab_err, max_out);
    end
    // A beat leaves on every ready-high (odd) cycle: last one in cycle 65.
    checks++;
    if (done_cyc != 2 * NREGS + 2 || done_cnt != 1) begin
      failures++; $display("FAIL toggle_done got cyc=%0d cnt=%0d exp cyc=%0d cnt=1", done_cyc, done_cnt, 2 * NREGS + 2);
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] pc = rnd64();
    bit bad = 0;
    for (int i = 0; i < NREGS; i++) rf[i] = rnd64();
    run_dump(3, pc, -1, -1, 300);
    for (int i = 0; i < b_idx.size(); i++)
      if (b_idx[i] != i || b_data[i] !== rf[i]) bad = 1;
    foreach (iss[i]) if (iss[i] != i) bad = 1;
    checks++;
    if (bad || b_idx.size() != NREGS || iss.size() != NREGS) begin
      failures++; $display("FAIL bp_beats got beats=%0d reads=%0d clean=%b exp 32 32 1", b_idx.size(), iss.size(), !bad);
    end
    checks++;
    if (hold_out != 2 || max_out > 2 || stab_err != 0) begin
      failures++; $display("FAIL bp_buffered got hold_out=%0d max_out=%0d stab=%0d exp 2 <=2 0", hold_out, max_out, stab_err);
    end
    checks++;
    if (b_idx.size() > 6 && b_cyc[6] != 29) begin
      failures++; $display("FAIL bp_resume got cyc=%0d exp=29", b_cyc[6]);
    end
    checks++;
    if (done_cyc != NREGS + 3 + 20) begin
      failures++; $display("FAIL bp_done got=%0d exp=%0d", done_cyc, NREGS + 23);
    end
  endtask

  task automatic test_random_ready();
    for (int r = 0; r < 3; r++) begin
      logic [XLEN-1:0] pc = rnd64();
      bit bad = 0;
      for (int i = 0; i < NREGS; i++) rf[i] = rnd64();
      run_dump(2, pc, -1, -1, 2000);
      for (int i = 0; i < b_idx.size(); i++)
        if (b_idx[i] != i || b_data[i] !== rf[i] || b_pc[i] !== pc || b_last[i] !== (i == NREGS - 1)) bad = 1;
      checks++;
      if (bad || b_idx.size() != NREGS || done_cnt != 1 || stab_err != 0 || max_out > 2) begin
        failures++;
        $display("FAIL rand_ready[%0d] got beats=%0d clean=%b done=%0d stab=%0d max_out=%0d exp 32 1 1 0 <=2",
                 r, b_idx.size(), !bad, done_cnt, stab_err, max_out);
      end
      // Completion needs at least one ready-high cycle per beat after the first valid.
      checks++;
      if (done_cyc < NREGS + 3) begin
        failures++; $display("FAIL rand_done_latency got=%0d exp>=%0d", done_cyc, NREGS + 3);
      end
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    run_dump(0, rnd64(), -1, -1, 12);
    checks++;
    if (stall_cnt != 0 || b_idx.size() != 0 || iss.size() != 0 || done_cnt != 0) begin
      failures++; $display("FAIL enable_off got stall=%0d beats=%0d reads=%0d done=%0d exp all 0",
                           stall_cnt, b_idx.size(), iss.size(), done_cnt);
    end
    for (int i = 0; i < NREGS; i++) rf[i] = rnd64();
    run_dump(0, 64'h8000_1000, -1, 5, 200);
    checks++;
    if (b_idx.size() != NREGS || done_cyc != NREGS + 3 || b_data[NREGS-1] !== rf[NREGS-1]) begin
      failures++; $display("FAIL enable_drop got beats=%0d done=%0d exp beats=%0d done=%0d", b_idx.size(), done_cyc, NREGS, NREGS + 3);
    end
  endtask

  task automatic test_overrun();
    logic [XLEN-1:0] pc = 64'h8000_0040;
    bit bad = 0;
    for (int i = 0; i < NREGS; i++) rf[i] = rnd64();
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
    run_dump(0, pc, 10, -1, 200);
    for (int i = 0; i < b_idx.size(); i++)
      if (b_idx[i] != i || b_data[i] !== rf[i] || b_pc[i] !== pc || b_cyc[i] != 3 + i) bad = 1;
    checks++;
    if (bad || b_idx.size() != NREGS || done_cyc != NREGS + 3) begin
      failures++; $display("FAIL overrun_dump got beats=%0d clean=%b done=%0d exp 32 1 %0d", b_idx.size(), !bad, done_cyc, NREGS + 3);
    end
    checks++;
    if (ovr_first != 11 || got_overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_flag got first=%0d end=%b exp first=11 end=1", ovr_first, got_overrun);
    end
    checks++;
    if (stall_cnt != NREGS + 3 || done_cnt != 1) begin
      failures++; $display("FAIL overrun_no_second got stall=%0d done=%0d exp %0d 1", stall_cnt, done_cnt, NREGS + 3);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit bad = 0;
    bit seen = 0;
    @(negedge clock);
    commit_valid = 1'b1;
    commit_pc    = 64'h8000_2000;
    trace_ready  = 1'b1;
    for (int c = 1; c < 15; c++) begin
      @(negedge clock);
      commit_valid = 1'b0;
    end
    @(negedge clock);
    #1;
    checks++;
    if (trace_valid !== 1'b1 || core_stall !== 1'b1) begin
      failures++; $display("FAIL mid_dump_active got valid=%b stall=%b exp 1 1", trace_valid, core_stall);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({core_stall, rf_ren, trace_valid, trace_last, dump_done, overrun} !== 6'b0 ||
        rf_raddr !== '0 || trace_idx !== '0 || trace_data !== '0 || trace_pc !== '0) begin
      failures++;
      $display("FAIL reset_abort got ctrl=%b raddr=%0d idx=%0d data=%h pc=%h exp all zero",
               {core_stall, rf_ren, trace_valid, trace_last, dump_done, overrun},
               rf_raddr, trace_idx, trace_data, trace_pc);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      if (dump_done || trace_valid) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL reset_quiet got=activity exp=none"); end
    reset_n = 1'b1;
    for (int i = 0; i < NREGS; i++) rf[i] = rnd64();
    run_dump(0, 64'h8000_3000, -1, -1, 200);
    for (int i = 0; i < b_idx.size(); i++)
      if (b_idx[i] != i || b_data[i] !== rf[i] || b_pc[i] !== 64'h8000_3000) bad = 1;
    checks++;
    if (bad || b_idx.size() != NREGS || done_cyc != NREGS + 3 || got_overrun !== 1'b0) begin
      failures++; $display("FAIL post_reset_dump got beats=%0d clean=%b done=%0d ovr=%b exp 32 1 %0d 0",
                           b_idx.size(), !bad, done_cyc, got_overrun, NREGS + 3);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_ready_toggle();
    test_backpressure();
    test_random_ready();
    test_enable();
    test_overrun();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
